// File: rtl/prefix_adder_backend_if.sv
// ---------------------------------------------------------------------------
// prefix_adder_backend_if
// Operand and result handshake bundle for prefix_adder_backend.
//
// Both channels use the same valid/ready rule. The source raises valid and
// holds its payload stable until it sees valid & ready at a rising edge. The
// sink may raise or lower ready at any time. A transfer happens on exactly the
// edges where valid & ready are both high.
//
// Signals
//   in_valid / in_ready            operand channel handshake
//   in_a, in_b [WIDTH]             operand pair
//   in_tag [TAGW]                  user tag returned with the result
//   out_valid / out_ready          result channel handshake
//   out_sum [WIDTH], out_cout      a+b and carry out
//   out_tag [TAGW]                 tag of the result
// Modports
//   slave   the adder back end (consumes operands, produces results)
//   master  the environment (produces operands, consumes results)
// ---------------------------------------------------------------------------
interface prefix_adder_backend_if #(
    parameter int WIDTH = 64,
    parameter int TAGW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic [TAGW-1:0]  out_tag;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_tag
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_tag
    );
endinterface

// File: rtl/prefix_adder_backend.sv
// ---------------------------------------------------------------------------
// prefix_adder_backend
// Front end and back end around a non-stallable pipelined parallel-prefix
// adder core. Operands are encoded into per-bit kill/generate/propagate pairs
// for the core. A shadow pipe carries each operation's valid bit, its
// propagate vector and its tag alongside the core. When an operation leaves
// the core, its resolved carries are recombined into sum/cout and written
// into a show-ahead result FIFO. Issue credits equal to the FIFO depth mean
// the core can never deliver a result that has no FIFO slot.
//
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous active-high reset
//   bus (slave)            operand and result handshakes
//   kgp_to_core            encoded operands, pair [2i+1:2i] per bit:
//                          G=11, K=00, P=01
//   kgp_from_core          resolved core output, LAT cycles after input
//   o_dbg_credits          current issue-credit count
//   o_dbg_core_unresolved  high when a valid op leaves the core with any pair
//                          still in the P state
// ---------------------------------------------------------------------------
module prefix_adder_backend #(
    parameter int WIDTH = 64,
    parameter int LAT   = 5,
    parameter int DEPTH = 8,
    parameter int TAGW  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    prefix_adder_backend_if.slave        bus,
    output logic [2*WIDTH-1:0]           kgp_to_core,
    input  logic [2*WIDTH-1:0]           kgp_from_core,
    output logic [$clog2(DEPTH+1)-1:0]   o_dbg_credits,
    output logic                         o_dbg_core_unresolved
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshake qualifiers
    logic             w_fire;
    logic             w_pop;
    logic             w_push;
    logic             w_empty;
    logic             w_full;

    // Credits and FIFO bookkeeping
    logic [CW-1:0]    r_credits;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;

    // Shadow pipe, one entry per core register stage
    logic [LAT-1:0]   r_sh_vld;
    logic [WIDTH-1:0] r_sh_p   [LAT];
    logic [TAGW-1:0]  r_sh_tag [LAT];

    // Result recombination
    logic [WIDTH:0]   w_carry;
    logic             w_unres;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // FIFO storage
    logic [WIDTH-1:0] r_mem_sum  [DEPTH];
    logic             r_mem_cout [DEPTH];
    logic [TAGW-1:0]  r_mem_tag  [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready depends only on the registered credit count, so there is no
    // combinational path from out_ready back to in_ready.
    assign bus.in_ready = (r_credits != '0);
    assign w_fire       = bus.in_valid & bus.in_ready;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_pop        = ~w_empty & bus.out_ready;
    assign w_push       = r_sh_vld[LAT-1];

    assign o_dbg_credits = r_credits;

    // Operand encoding: bit 1 = a&b (generate), bit 0 = a|b. This yields
    // G=11, K=00 and P=01 directly. Carry-in is implicitly zero.
    always_comb begin
        kgp_to_core = '0;
        for (int i = 0; i < WIDTH; i++) begin
            kgp_to_core[2*i+1] = bus.in_a[i] & bus.in_b[i];
            kgp_to_core[2*i]   = bus.in_a[i] | bus.in_b[i];
        end
    end

    // Every core position resolves to K or G. The high bit of pair i is the
    // carry into bit i+1. Both bits of a pair must agree; any disagreement is
    // flagged on the debug output.
    always_comb begin
        w_carry = '0;
        w_unres = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry[i+1] = kgp_from_core[2*i+1];
            w_unres      = w_unres | (kgp_from_core[2*i+1] ^ kgp_from_core[2*i]);
        end
    end

    assign w_sum                 = r_sh_p[LAT-1] ^ w_carry[WIDTH-1:0];
    assign w_cout                = w_carry[WIDTH];
    assign o_dbg_core_unresolved = r_sh_vld[LAT-1] & w_unres;

    // Shadow pipe. Stage 0 loads on every edge, so idle cycles carry vld=0.
    // Whatever the core emits for those slots is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_vld <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_sh_p[s]   <= '0;
                r_sh_tag[s] <= '0;
            end
        end else begin
            r_sh_vld[0] <= w_fire;
            r_sh_p[0]   <= bus.in_a ^ bus.in_b;
            r_sh_tag[0] <= bus.in_tag;
            for (int s = 1; s < LAT; s++) begin
                r_sh_vld[s] <= r_sh_vld[s-1];
                r_sh_p[s]   <= r_sh_p[s-1];
                r_sh_tag[s] <= r_sh_tag[s-1];
            end
        end
    end

    // Credits: one per FIFO slot. An op gives up its credit when it issues
    // and gets it back when its result is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credits <= CW'(DEPTH);
        end else if (w_fire && !w_pop) begin
            r_credits <= r_credits - CW'(1);
        end else if (!w_fire && w_pop) begin
            r_credits <= r_credits + CW'(1);
        end
    end

    // Result FIFO. Storage is cleared on reset so the outputs read 0 until
    // the first result arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem_sum[k]  <= '0;
                r_mem_cout[k] <= 1'b0;
                r_mem_tag[k]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_sum[r_wr_ptr]  <= w_sum;
                r_mem_cout[r_wr_ptr] <= w_cout;
                r_mem_tag[r_wr_ptr]  <= r_sh_tag[LAT-1];
                r_wr_ptr             <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign bus.out_valid = ~w_empty;
    assign bus.out_sum   = r_mem_sum[r_rd_ptr];
    assign bus.out_cout  = r_mem_cout[r_rd_ptr];
    assign bus.out_tag   = r_mem_tag[r_rd_ptr];

    // A push into a full FIFO is only legal when a pop happens on the same edge.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_full && !w_pop));

    // Every credit is in exactly one place: free, in flight, or queued.
    a_credit_conservation: assert property (@(posedge clk) disable iff (reset)
        ($countones(r_sh_vld) + int'(r_count) + int'(r_credits)) == DEPTH);

endmodule

// File: tb/tb_prefix_adder_backend.sv
// ---------------------------------------------------------------------------
// tb_prefix_adder_backend
// Drives prefix_adder_backend with a behavioural LAT-stage prefix core
// between kgp_to_core and kgp_from_core. Expected results come from a plain
// a+b model that is queued when an operand is accepted.
// ---------------------------------------------------------------------------
module tb_prefix_adder_backend;
  localparam int WIDTH = 64;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;
  localparam int TAGW  = 4;
  localparam int EW    = TAGW + 1 + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prefix_adder_backend_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();

  logic [2*WIDTH-1:0]         kgp_to_core;
  logic [2*WIDTH-1:0]         kgp_from_core;
  logic [$clog2(DEPTH+1)-1:0] dbg_credits;
  logic                       dbg_unres;

  prefix_adder_backend #(
    .WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .bus                   (bus),
    .kgp_to_core           (kgp_to_core),
    .kgp_from_core         (kgp_from_core),
    .o_dbg_credits         (dbg_credits),
    .o_dbg_core_unresolved (dbg_unres)
  );

  // ---------------- behavioural prefix core (never reset) ----------------
  function automatic logic [2*WIDTH-1:0] resolve(input logic [2*WIDTH-1:0] k);
    logic [2*WIDTH-1:0] r;
    logic c;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (k[2*i+1 -: 2] == 2'b11) c = 1'b1;
      else if (k[2*i+1 -: 2] == 2'b00) c = 1'b0;
      r[2*i+1] = c;
      r[2*i]   = c;
    end
    return r;
  endfunction

  logic [2*WIDTH-1:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= resolve(kgp_to_core);
    for (int s = 1; s < LAT; s++) core_pipe[s] <= core_pipe[s-1];
  end
  assign kgp_from_core = core_pipe[LAT-1];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mon_en) begin
      check("credits", 64'(dbg_credits), 64'(DEPTH - exp_q.size()));
      check("core_res", 64'(dbg_unres), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("ghost", 64'(bus.out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum", bus.out_sum, e[WIDTH-1:0]);
          check("cout", 64'(bus.out_cout), 64'(e[WIDTH]));
          check("tag", 64'(bus.out_tag), 64'(e[EW-1 -: TAGW]));
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.in_tag, 65'({1'b0, bus.in_a} + {1'b0, bus.in_b})});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [TAGW-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      @(posedge clk); #1;
    end
    if (!bus.in_ready) check("send_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Counts edges from the operand's capture edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) check("wait_valid", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Holds in_valid high for 20 cycles with out_ready low; counts accepts.
  task automatic fill(input int base, output int acc);
    int idx;
    idx = base;
    acc = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 64'(idx * 3 + 1);
      bus.in_b     = 64'(idx) << 40;
      bus.in_tag   = TAGW'(idx);
      @(negedge clk);
      if (bus.in_ready) begin
        acc++;
        idx++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int acc;
    int fires;
    int pops;
    int cyc;
    int idx;
    bit last_fire;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum", bus.out_sum, 64'd0);
    check("rst_out_cout", 64'(bus.out_cout), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_credits", 64'(dbg_credits), 64'd8);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // All-ones + 1: full carry ripple, latency LAT+1
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd3);
    wait_valid(n);
    check("lat", 64'(n), 64'(LAT + 1));
    check("ff_sum", bus.out_sum, 64'd0);
    check("ff_cout", 64'(bus.out_cout), 64'd1);
    check("ff_tag", 64'(bus.out_tag), 64'd3);
    @(posedge clk); #1;

    // Back-to-back: 0+0 then msb+msb
    send(64'd0, 64'd0, 4'd1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd2);
    wait_valid(n);
    check("b2b0_sum", bus.out_sum, 64'd0);
    check("b2b0_cout", 64'(bus.out_cout), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b1_valid", 64'(bus.out_valid), 64'd1);
    check("b2b1_sum", bus.out_sum, 64'd0);
    check("b2b1_cout", 64'(bus.out_cout), 64'd1);
    check("b2b1_tag", 64'(bus.out_tag), 64'd2);
    @(posedge clk); #1;
    drain();

    // Backpressure: exactly DEPTH accepted, then release
    fill(0, acc);
    check("bp_accepted", 64'(acc), 64'd8);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_rdy_pre", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_rdy_post", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    drain();

    // Full FIFO, then sustained in_valid & out_ready for 30 cycles
    fill(100, acc);
    check("full_accepted", 64'(acc), 64'd8);
    bus.out_ready = 1'b1;
    fires = 0;
    pops  = 0;
    idx   = 200;
    for (int k = 0; k < 30; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 64'hFFFF_FFFF_0000_0000 + 64'(idx);
      bus.in_b     = 64'(idx) << 32;
      bus.in_tag   = TAGW'(idx);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) pops++;
      if (bus.in_valid && bus.in_ready) begin
        fires++;
        idx++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("sust_fires", 64'(fires), 64'd29);
    check("sust_pops", 64'(pops), 64'd30);
    drain();

    // Random traffic with random valid/ready
    fires = 0;
    cyc = 0;
    last_fire = 1'b0;
    bus.in_valid = 1'b0;
    while (fires < 1000 && cyc < 20000) begin
      if (!bus.in_valid || last_fire) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_a     = ($urandom_range(0, 3) == 0) ? ~64'(0) - 64'($urandom_range(0, 3))
                                                   : {$urandom, $urandom};
        bus.in_b     = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7))
                                                   : {$urandom, $urandom};
        bus.in_tag   = TAGW'($urandom_range(0, 15));
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      last_fire = bus.in_valid && bus.in_ready;
      if (last_fire) fires++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("rand_count", 64'(fires), 64'd1000);
    drain();

    // Reset with 2 queued and 4 in flight
    bus.out_ready = 1'b0;
    send(64'd10, 64'd20, 4'd4);
    send(64'd30, 64'd40, 4'd5);
    repeat (LAT + 3) @(posedge clk);
    #1;
    send(64'd1, 64'd1, 4'd6);
    send(64'd2, 64'd2, 4'd7);
    send(64'd3, 64'd3, 4'd8);
    send(64'd4, 64'd4, 4'd9);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    exp_q.delete();
    #1;
    check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_credits", 64'(dbg_credits), 64'd8);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    send(64'd5, 64'd7, 4'd9);
    wait_valid(n);
    check("mrst_lat", 64'(n), 64'(LAT + 1));
    check("mrst_sum", bus.out_sum, 64'd12);
    check("mrst_cout", 64'(bus.out_cout), 64'd0);
    check("mrst_tag", 64'(bus.out_tag), 64'd9);
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    check("mrst_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
